// File: rtl/time_uart_tx.sv
`timescale 1ns/1ps
// time_uart_tx: snapshots the two display numbers and the clock/timer mode on a
// send request, then emits "<M><H1><H0>:<L1><L0>\r\n" as 8N1 UART characters,
// LSB first. The binary-to-decimal split is done here on the snapshot.
module time_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] num1,
  input  logic [5:0] num0,
  input  logic       mode,
  input  logic       send,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [2:0]       char_idx_reg;
  logic [5:0]       num1_reg;
  logic [5:0]       num0_reg;
  logic             mode_reg;
  logic             txd_reg;
  logic             busy_reg;
  logic             done_reg;

  // Snapshot values in a small array so both numbers share one digit splitter.
  // Index 0 is the low number, index 1 the high number.
  logic [5:0] snap_val [2];
  logic [7:0] tens_char [2];
  logic [7:0] ones_char [2];

  assign snap_val[0] = num0_reg;
  assign snap_val[1] = num1_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      // Thermometer of "value >= 10, 20, ... 60"; its popcount is the tens digit.
      // 60..63 simply produce tens = 6, no clamping.
      logic [5:0] ge_flags;
      logic [2:0] tens;
      logic [5:0] tens_x10;
      logic [5:0] ones;

      for (gj = 0; gj < 6; gj++) begin : g_thresh
        assign ge_flags[gj] = (snap_val[gi] >= 6'(10 * (gj + 1)));
      end

      // Count the thresholds crossed to get the tens digit
      always_comb begin
        tens = 3'd0;
        for (int k = 0; k < 6; k++) begin
          tens = tens + {2'b00, ge_flags[k]};
        end
      end

      // tens*10 as tens*8 + tens*2, then the remainder is the ones digit (< 10)
      assign tens_x10      = {tens, 3'b000} + {2'b00, tens, 1'b0};
      assign ones          = snap_val[gi] - tens_x10;
      assign tens_char[gi] = 8'h30 + {5'b00000, tens};
      assign ones_char[gi] = 8'h30 + {2'b00, ones};
    end
  endgenerate

  // Frame character table, selected by the character index
  logic [7:0] frame_char [8];

  assign frame_char[0] = mode_reg ? 8'h54 : 8'h43;
  assign frame_char[1] = tens_char[1];
  assign frame_char[2] = ones_char[1];
  assign frame_char[3] = 8'h3A;
  assign frame_char[4] = tens_char[0];
  assign frame_char[5] = ones_char[0];
  assign frame_char[6] = 8'h0D;
  assign frame_char[7] = 8'h0A;

  logic [7:0] cur_char;
  logic [2:0] bit_idx_next;

  assign cur_char     = frame_char[char_idx_reg];
  assign bit_idx_next = bit_idx_reg + 3'd1;

  // Transmit FSM: all outputs registered so txd never glitches
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= 3'd0;
      char_idx_reg <= 3'd0;
      num1_reg     <= 6'd0;
      num0_reg     <= 6'd0;
      mode_reg     <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          txd_reg  <= 1'b1;
          busy_reg <= 1'b0;
          if (send) begin
            // Snapshot so input changes mid-frame cannot corrupt the frame
            num1_reg     <= num1;
            num0_reg     <= num0;
            mode_reg     <= mode;
            char_idx_reg <= 3'd0;
            bit_idx_reg  <= 3'd0;
            cnt_reg      <= CNT_LOAD;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ST_START;
          end
        end

        ST_START: begin
          if (cnt_reg == '0) begin
            cnt_reg     <= CNT_LOAD;
            bit_idx_reg <= 3'd0;
            txd_reg     <= cur_char[0];
            state_reg   <= ST_DATA;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt_reg == '0) begin
            cnt_reg <= CNT_LOAD;
            if (bit_idx_reg == 3'd7) begin
              txd_reg   <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_next;
              txd_reg     <= cur_char[bit_idx_next];
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_STOP: begin
          if (cnt_reg == '0) begin
            if (char_idx_reg == 3'd7) begin
              // Last stop bit finished: return to idle and flag completion.
              // The character index wraps to 0 only here.
              char_idx_reg <= 3'd0;
              bit_idx_reg  <= 3'd0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              txd_reg      <= 1'b1;
              state_reg    <= ST_IDLE;
            end else begin
              // Next character starts immediately, no idle gap
              char_idx_reg <= char_idx_reg + 3'd1;
              cnt_reg      <= CNT_LOAD;
              txd_reg      <= 1'b0;
              state_reg    <= ST_START;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign txd  = txd_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
